spi_ctrl: RTL and testbench

- Sequencing FSM for the SPI datapath: generates the shift-register load, per-bit shift enable, MOSI tristate enable, receive-buffer load strobe (done), SCLK and active-low chip select.
- One full-duplex WIDTH-bit transfer per start request, SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits between the CPU-side command logic and the datapath. The datapath is unchanged; this block owns all of its control pins.

---
 rtl/spi_ctrl.sv | 138 +++++++++++++
 tb/tb_spi_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_ctrl.sv
// rtl/spi_ctrl.sv - SPI mode-0 transfer sequencer driving the shift datapath control pins
//
// Purpose: one full-duplex WIDTH-bit MSB-first transfer per start request.
//          Sequence: IDLE -> LOAD -> LEAD -> (HIGH -> LOW) x WIDTH -> TRAIL -> DONE -> IDLE.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         transfer request, sampled only in IDLE
//   sclk          SPI serial clock (CPOL=0)
//   cs_n          chip select, active low
//   i_load        parallel-load strobe to datapath shift register
//   i_en          one-cycle shift enable per bit (captures MISO)
//   tbuf_mosi_oe  MOSI tristate enable
//   done          one-cycle strobe, loads datapath receive buffer
//   busy          high from LOAD through DONE inclusive
module spi_ctrl #(
    parameter int WIDTH  = 16,
    parameter int CLKDIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic sclk,
    output logic cs_n,
    output logic i_load,
    output logic i_en,
    output logic tbuf_mosi_oe,
    output logic done,
    output logic busy
);

    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TRAIL,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_cnt_nx;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_bit_cnt_nx;
    logic             w_div_exp;
    logic             w_timed_nx;

    logic w_sclk_nx;
    logic w_cs_n_nx;
    logic w_load_nx;
    logic w_en_nx;
    logic w_oe_nx;
    logic w_done_nx;
    logic w_busy_nx;

    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_div_exp    = (r_div_cnt == DIV_LAST);

        case (r_state)
            S_IDLE:  if (start) w_state_nx = S_LOAD;
            S_LOAD: begin
                w_bit_cnt_nx = '0;
                w_state_nx   = S_LEAD;
            end
            S_LEAD:  if (w_div_exp) w_state_nx = S_HIGH;
            S_HIGH:  if (w_div_exp) w_state_nx = S_LOW;
            S_LOW: begin
                if (w_div_exp) begin
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nx = S_TRAIL;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                        w_state_nx   = S_HIGH;
                    end
                end
            end
            S_TRAIL: if (w_div_exp) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase

        // The divider only runs inside the timed states and restarts on every transition.
        w_timed_nx = (w_state_nx == S_LEAD) || (w_state_nx == S_HIGH) ||
                     (w_state_nx == S_LOW)  || (w_state_nx == S_TRAIL);
        if (!w_timed_nx || (w_state_nx != r_state)) begin
            w_div_cnt_nx = '0;
        end else begin
            w_div_cnt_nx = r_div_cnt + 1'b1;
        end

        // Outputs are the Moore decode of the next state, registered below, so each
        // output equals the decode of the current state but comes straight from a flop.
        w_sclk_nx = (w_state_nx == S_HIGH);
        w_cs_n_nx = (w_state_nx == S_IDLE) || (w_state_nx == S_DONE);
        w_load_nx = (w_state_nx == S_LOAD);
        w_en_nx   = (w_state_nx == S_HIGH) && (w_div_cnt_nx == '0);
        w_oe_nx   = !w_cs_n_nx;
        w_done_nx = (w_state_nx == S_DONE);
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            sclk         <= 1'b0;
            cs_n         <= 1'b1;
            i_load       <= 1'b0;
            i_en         <= 1'b0;
            tbuf_mosi_oe <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_div_cnt    <= w_div_cnt_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            sclk         <= w_sclk_nx;
            cs_n         <= w_cs_n_nx;
            i_load       <= w_load_nx;
            i_en         <= w_en_nx;
            tbuf_mosi_oe <= w_oe_nx;
            done         <= w_done_nx;
            busy         <= w_busy_nx;
        end
    end

endmodule

// File: tb/tb_spi_ctrl.sv
// tb/tb_spi_ctrl.sv - self-checking bench for spi_ctrl with datapath and slave models
module tb_spi_ctrl;

    localparam int W  = 16;
    localparam int D  = 2;
    localparam int W8 = 8;
    localparam int D8 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, sclk, cs_n, i_load, i_en, oe, done, busy;
    logic rst_8, start_8, sclk_8, cs_n_8, i_load_8, i_en_8, oe_8, done_8, busy_8;

    int n_vec = 0;
    int n_err = 0;

    spi_ctrl #(.WIDTH(W), .CLKDIV(D)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sclk(sclk), .cs_n(cs_n),
        .i_load(i_load), .i_en(i_en), .tbuf_mosi_oe(oe), .done(done), .busy(busy)
    );

    spi_ctrl #(.WIDTH(W8), .CLKDIV(D8)) u_dut8 (
        .clk(clk), .rst(rst_8), .start(start_8), .sclk(sclk_8), .cs_n(cs_n_8),
        .i_load(i_load_8), .i_en(i_en_8), .tbuf_mosi_oe(oe_8), .done(done_8), .busy(busy_8)
    );

    // Datapath shift register, receive buffer and a mode-0 slave on the MISO side.
    logic [W-1:0] dp_tx, dp_sr, rx_buf, slave_word, slave_sr;
    logic         loopback, sclk_d;
    logic         mosi, miso;

    assign mosi = dp_sr[W-1];
    assign miso = loopback ? mosi : slave_sr[W-1];

    always @(posedge clk) begin
        sclk_d <= sclk;
        if (i_load)    dp_sr <= dp_tx;
        else if (i_en) dp_sr <= {dp_sr[W-2:0], miso};
        if (done) rx_buf <= dp_sr;
        if (i_load)                slave_sr <= slave_word;
        else if (sclk_d && !sclk)  slave_sr <= {slave_sr[W-2:0], 1'b0};
    end

    // Expected {sclk, cs_n, load, en, oe, done, busy} at cycle t after the LOAD cycle.
    function automatic logic [6:0] exp_out(int t, int w, int d);
        int L, u;
        logic s, c, l, e, o, dn, b;
        L = 2 + d * (2 * w + 2);
        s = 0; c = 1; l = 0; e = 0; o = 0; dn = 0; b = 0;
        if (t == 0) begin
            c = 0; l = 1; o = 1; b = 1;
        end else if (t == L - 1) begin
            dn = 1; b = 1;
        end else if (t > 0 && t < L - 1) begin
            c = 0; o = 1; b = 1;
            u = t - 1 - d;
            if (u >= 0 && u < 2 * w * d && (u % (2 * d)) < d) begin
                s = 1;
                e = ((u % (2 * d)) == 0);
            end
        end
        return {s, c, l, e, o, dn, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw,
                            input logic lb, input int pulse_t);
        int L, nrise, nen, ndone;
        logic [W-1:0] mosi_bits;
        logic prev_sclk;
        L = 2 + D * (2 * W + 2);
        dp_tx = tx; slave_word = sw; loopback = lb;
        mosi_bits = '0; nrise = 0; nen = 0; ndone = 0; prev_sclk = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= L; t++) begin
            check("outs", {25'd0, sclk, cs_n, i_load, i_en, oe, done, busy}, {25'd0, exp_out(t, W, D)});
            if (sclk && !prev_sclk) begin
                mosi_bits = {mosi_bits[W-2:0], mosi};
                nrise++;
            end
            if (i_en) nen++;
            if (done) ndone++;
            prev_sclk = sclk;
            start = (t == pulse_t);
            step();
        end
        start = 1'b0;
        check("sclk_rises", nrise, W);
        check("en_pulses", nen, W);
        check("done_pulses", ndone, 1);
        check("mosi_bits", {16'd0, mosi_bits}, {16'd0, tx});
        check("rx_buf", {16'd0, rx_buf}, {16'd0, lb ? tx : sw});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nen8;
        logic [W-1:0] tx, sw;
        rst = 1'b1; rst_8 = 1'b1; start = 1'b0; start_8 = 1'b0;
        dp_tx = '0; slave_word = '0; loopback = 1'b0;
        step(); step();
        check("reset_outs", {25'd0, sclk, cs_n, i_load, i_en, oe, done, busy}, 32'b0100000);
        check("reset_outs8", {25'd0, sclk_8, cs_n_8, i_load_8, i_en_8, oe_8, done_8, busy_8}, 32'b0100000);
        rst = 1'b0; rst_8 = 1'b0;
        step(); step();

        run_xfer(16'hA5C3, 16'h0000, 1'b1, -1);
        run_xfer(16'h0000, 16'h3C5A, 1'b0, -1);
        // Extra start at the first HIGH cycle of bit 5 must be ignored.
        run_xfer(16'($urandom), 16'($urandom), 1'b0, 1 + D + 2 * D * 5);
        for (int k = 0; k < 3; k++) begin
            tx = 16'($urandom);
            sw = 16'($urandom);
            repeat ($urandom_range(0, 3)) step();
            run_xfer(tx, sw, k[0], -1);
        end

        // Async reset at the first HIGH cycle of bit 8.
        dp_tx = 16'($urandom); slave_word = 16'($urandom); loopback = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (1 + D + 2 * D * 8) step();
        check("pre_rst_outs", {25'd0, sclk, cs_n, i_load, i_en, oe, done, busy},
              {25'd0, exp_out(1 + D + 2 * D * 8, W, D)});
        #1 rst = 1'b1;
        #1 check("rst_async", {29'd0, sclk, cs_n, busy}, 32'b010);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_hold_outs", {25'd0, sclk, cs_n, i_load, i_en, oe, done, busy}, 32'b0100000);
        end
        rst = 1'b0;
        step();
        check("post_rst_idle", {25'd0, sclk, cs_n, i_load, i_en, oe, done, busy}, 32'b0100000);
        run_xfer(16'($urandom), 16'($urandom), 1'b0, -1);

        // WIDTH=8, CLKDIV=1 with start held: 20-cycle transfers, one IDLE cycle between.
        start_8 = 1'b1;
        step();
        nen8 = 0;
        for (int c = 0; c < 3 * 21; c++) begin
            check("outs8", {25'd0, sclk_8, cs_n_8, i_load_8, i_en_8, oe_8, done_8, busy_8},
                  {25'd0, exp_out(c % 21, W8, D8)});
            if (i_en_8) nen8++;
            if ((c % 21) == 19) begin
                check("en_pulses8", nen8, W8);
                nen8 = 0;
            end
            step();
        end
        start_8 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
